// File: rtl/sram_bridge_pkg.sv
// Shared encodings for the SRAM bridge: access sizes, FSM states and
// store-lane helpers used by the top level.
package sram_bridge_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  // Offset is only meaningful for byte/half; illegal sizes never reach the SRAM.
  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  return 4'b0001 << offset;
      SIZE_H:  return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_B:  return {4{data[7:0]}};
      SIZE_H:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/sram_bridge_load_align.sv
// Load alignment: shifts the addressed lane down to bit 0, then masks to the
// access size and sign- or zero-extends.
module sram_bridge_load_align
  import sram_bridge_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = data_i >> {offset_i, 3'b000};

  always_comb begin
    result_o = shifted;
    case (size_i)
      SIZE_B:  result_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_H:  result_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/sram_bridge.sv
// Single-outstanding request bridge from a byte-addressed load/store port
// onto a word-wide SRAM with one-cycle read latency.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter  int DEPTH    = 1024,
  localparam int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_rdata,
  output logic                resp_error,
  output logic                sram_read_req,
  output logic [LOGDEPTH-1:0] sram_read_addr,
  input  logic [31:0]         sram_read_data,
  output logic                sram_write_req,
  output logic [LOGDEPTH-1:0] sram_write_addr,
  output logic [3:0]          sram_write_byte_en,
  output logic [31:0]         sram_write_data
);

  localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

  state_e      state_q;
  logic        respValid_q;
  logic        respError_q;
  logic [31:0] respData_q;
  logic [1:0]  loadOffset_q;
  logic [1:0]  loadSize_q;
  logic        loadSigned_q;

  logic        accept;
  logic        misaligned;
  logic        outOfRange;
  logic        reqError;
  logic [31:0] alignedData;

  assign misaligned = ((req_size == SIZE_H) && req_addr[0]) ||
                      ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
  assign outOfRange = req_addr[31:2] >= DEPTH_WORDS;
  assign reqError   = (req_size == SIZE_X) || misaligned || outOfRange;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // SRAM strobes are combinational so a store commits on the accept edge.
  assign sram_read_req      = accept && !req_write && !reqError;
  assign sram_write_req     = accept &&  req_write && !reqError;
  assign sram_read_addr     = req_addr[LOGDEPTH+1:2];
  assign sram_write_addr    = req_addr[LOGDEPTH+1:2];
  assign sram_write_byte_en = byteEnable(req_size, req_addr[1:0]);
  assign sram_write_data    = storeData(req_size, req_wdata);

  sram_bridge_load_align u_load_align (
    .data_i   (sram_read_data),
    .offset_i (loadOffset_q),
    .size_i   (loadSize_q),
    .signed_i (loadSigned_q),
    .result_o (alignedData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      respValid_q  <= 1'b0;
      respError_q  <= 1'b0;
      respData_q   <= '0;
      loadOffset_q <= '0;
      loadSize_q   <= SIZE_B;
      loadSigned_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            respError_q  <= reqError;
            respData_q   <= '0;
            loadOffset_q <= req_addr[1:0];
            loadSize_q   <= req_size;
            loadSigned_q <= req_signed;
            if (reqError || req_write) begin
              respValid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          respData_q  <= alignedData;
          respError_q <= 1'b0;
          respValid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            respValid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = respValid_q;
  assign resp_rdata = respData_q;
  assign resp_error = respError_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge with a behavioural SRAM model holding
// hand-computed contents.
module tb_sram_bridge;
  import sram_bridge_pkg::*;

  localparam int DEPTH    = 64;
  localparam int LOGDEPTH = $clog2(DEPTH);

  logic                clk;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [31:0]         req_addr;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [31:0]         req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [31:0]         resp_rdata;
  logic                resp_error;
  logic                sram_read_req;
  logic [LOGDEPTH-1:0] sram_read_addr;
  logic [31:0]         sram_read_data;
  logic                sram_write_req;
  logic [LOGDEPTH-1:0] sram_write_addr;
  logic [3:0]          sram_write_byte_en;
  logic [31:0]         sram_write_data;

  logic [31:0]         mem [DEPTH];
  logic                preloadEn;
  logic [LOGDEPTH-1:0] preloadAddr;
  logic [31:0]         preloadData;

  int testsRun    = 0;
  int testsFailed = 0;

  sram_bridge #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_size           (req_size),
    .req_signed         (req_signed),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_rdata         (resp_rdata),
    .resp_error         (resp_error),
    .sram_read_req      (sram_read_req),
    .sram_read_addr     (sram_read_addr),
    .sram_read_data     (sram_read_data),
    .sram_write_req     (sram_write_req),
    .sram_write_addr    (sram_write_addr),
    .sram_write_byte_en (sram_write_byte_en),
    .sram_write_data    (sram_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-enabled write on the strobe edge, read data the cycle after.
  always @(posedge clk) begin
    if (preloadEn) begin
      mem[preloadAddr] <= preloadData;
    end else if (sram_write_req) begin
      for (int b = 0; b < 4; b++)
        if (sram_write_byte_en[b]) mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
    end
    if (sram_read_req) sram_read_data <= mem[sram_read_addr];
  end

  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] addr,
                               input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
    req_valid  = v;
    req_write  = w;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
  endtask

  task automatic drainResponse();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    @(negedge clk);
    testsRun++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_error !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got rdy=%b vld=%b err=%b expected 0 0 0", req_ready, resp_valid, resp_error);
    end
    testsRun++;
    if (resp_rdata !== 32'h0 || sram_read_req !== 1'b0 || sram_write_req !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got rdata=%08h rreq=%b wreq=%b expected 0 0 0", resp_rdata, sram_read_req, sram_write_req);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] addrs [8] = '{32'd0, 32'd2, 32'd2, 32'd3, 32'd1, 32'd0, 32'd0, 32'd3};
    logic [1:0]  sizes [8] = '{SIZE_B, SIZE_H, SIZE_H, SIZE_B, SIZE_B, SIZE_H, SIZE_W, SIZE_B};
    logic        sgns  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exps  [8] = '{32'hFFFFFFA5, 32'h00008000, 32'hFFFF8000, 32'h00000080,
                               32'hFFFFFFF0, 32'h0000F0A5, 32'h8000F0A5, 32'hFFFFFF80};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, addrs[i], sizes[i], sgns[i], 32'h0);
      #1;
      testsRun++;
      if (req_ready !== 1'b1 || sram_read_req !== 1'b1 || sram_write_req !== 1'b0 || sram_read_addr !== 6'd0) begin
        testsFailed++;
        $display("[TB] FAIL load%0d_accept: got rdy=%b rreq=%b wreq=%b raddr=%0d expected 1 1 0 0",
                 i, req_ready, sram_read_req, sram_write_req, sram_read_addr);
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
      testsRun++;
      if (resp_valid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL load%0d_early_valid: got %b expected 0", i, resp_valid);
      end
      @(negedge clk);
      testsRun++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== exps[i]) begin
        testsFailed++;
        $display("[TB] FAIL load%0d_resp: got vld=%b err=%b rdata=%08h expected 1 0 %08h",
                 i, resp_valid, resp_error, resp_rdata, exps[i]);
      end
      drainResponse();
    end
  endtask

  task automatic test_store();
    logic [31:0] addrs [3] = '{32'd5, 32'd6, 32'd8};
    logic [1:0]  sizes [3] = '{SIZE_B, SIZE_H, SIZE_W};
    logic [31:0] wdats [3] = '{32'h000000CC, 32'h1234ABCD, 32'hDEADBEEF};
    logic [3:0]  bes   [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] lanes [3] = '{32'hCCCCCCCC, 32'hABCDABCD, 32'hDEADBEEF};
    logic [5:0]  words [3] = '{6'd1, 6'd1, 6'd2};
    logic [31:0] mems  [3] = '{32'h1122CC44, 32'hABCDCC44, 32'hDEADBEEF};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, addrs[i], sizes[i], 1'b0, wdats[i]);
      #1;
      testsRun++;
      if (sram_write_req !== 1'b1 || sram_read_req !== 1'b0 || sram_write_byte_en !== bes[i] ||
          sram_write_data !== lanes[i] || sram_write_addr !== words[i]) begin
        testsFailed++;
        $display("[TB] FAIL store%0d_port: got wreq=%b rreq=%b be=%b wdata=%08h waddr=%0d expected 1 0 %b %08h %0d",
                 i, sram_write_req, sram_read_req, sram_write_byte_en, sram_write_data, sram_write_addr,
                 bes[i], lanes[i], words[i]);
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
      testsRun++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin
        testsFailed++;
        $display("[TB] FAIL store%0d_resp: got vld=%b err=%b rdata=%08h expected 1 0 00000000",
                 i, resp_valid, resp_error, resp_rdata);
      end
      testsRun++;
      if (mem[words[i]] !== mems[i]) begin
        testsFailed++;
        $display("[TB] FAIL store%0d_mem: got %08h expected %08h", i, mem[words[i]], mems[i]);
      end
      drainResponse();
    end
  endtask

  task automatic test_errors();
    logic        wrs   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] addrs [5] = '{32'd2, 32'd1, 32'd0, 32'(4*DEPTH), 32'd3};
    logic [1:0]  sizes [5] = '{SIZE_W, SIZE_H, SIZE_X, SIZE_W, SIZE_H};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, wrs[i], addrs[i], sizes[i], 1'b1, 32'hFFFFFFFF);
      #1;
      testsRun++;
      if (sram_read_req !== 1'b0 || sram_write_req !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL err%0d_no_sram: got rreq=%b wreq=%b expected 0 0", i, sram_read_req, sram_write_req);
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
      testsRun++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0) begin
        testsFailed++;
        $display("[TB] FAIL err%0d_resp: got vld=%b err=%b rdata=%08h expected 1 1 00000000",
                 i, resp_valid, resp_error, resp_rdata);
      end
      drainResponse();
    end
    testsRun++;
    if (mem[0] !== 32'h8000F0A5) begin
      testsFailed++;
      $display("[TB] FAIL err_mem_untouched: got %08h expected 8000f0a5", mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b0, 32'd0, SIZE_W, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd4, SIZE_W, 1'b0, 32'h0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      testsRun++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h8000F0A5 || req_ready !== 1'b0 || sram_read_req !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL hold%0d: got vld=%b rdata=%08h rdy=%b rreq=%b expected 1 8000f0a5 0 0",
                 c, resp_valid, resp_rdata, req_ready, sram_read_req);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    testsRun++;
    if (req_ready !== 1'b1 || sram_read_req !== 1'b1 || sram_read_addr !== 6'd1 || resp_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hold_release: got rdy=%b rreq=%b raddr=%0d vld=%b expected 1 1 1 0",
               req_ready, sram_read_req, sram_read_addr, resp_valid);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    @(negedge clk);
    testsRun++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hABCDCC44) begin
      testsFailed++;
      $display("[TB] FAIL second_load: got vld=%b rdata=%08h expected 1 abcdcc44", resp_valid, resp_rdata);
    end
    drainResponse();
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 1'b0, 32'd0, SIZE_B, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    testsRun++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_in: got vld=%b rdy=%b expected 0 0", resp_valid, req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_after: got vld=%b rdy=%b expected 0 1", resp_valid, req_ready);
    end
    applyStimulus(1'b1, 1'b0, 32'd0, SIZE_H, 1'b1, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    @(negedge clk);
    testsRun++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== 32'hFFFFF0A5) begin
      testsFailed++;
      $display("[TB] FAIL midreset_next_load: got vld=%b err=%b rdata=%08h expected 1 0 fffff0a5",
               resp_valid, resp_error, resp_rdata);
    end
    drainResponse();
  endtask

  initial begin
    reset       = 1'b1;
    resp_ready  = 1'b0;
    preloadEn   = 1'b0;
    preloadAddr = '0;
    preloadData = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    @(negedge clk);
    preloadEn   = 1'b1;
    preloadAddr = 6'd0;
    preloadData = 32'h8000F0A5;
    @(negedge clk);
    preloadAddr = 6'd1;
    preloadData = 32'h11223344;
    @(negedge clk);
    preloadAddr = 6'd2;
    preloadData = 32'h00000000;
    @(negedge clk);
    preloadEn = 1'b0;

    test_reset();
    test_load();
    test_errors();
    test_store();
    test_back_to_back();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 Parameter: DEPTH, default 1024, SRAM depth in 32-bit words; LOGDEPTH = clog2(DEPTH), derived locally.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  bridge accepts a request this cycle.
REQ-007 req_write  in  1  1=store, 0=load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 resp_valid  out  1  response present.
REQ-013 resp_ready  in  1  consumer takes response.
REQ-014 resp_rdata  out  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-015 resp_error  out  1  request rejected: misaligned, illegal size, or out of range.
REQ-016 sram_read_req / sram_read_addr / sram_read_data  out 1 / out LOGDEPTH / in 32  SRAM read port; data valid the cycle after the request.
REQ-017 sram_write_req / sram_write_addr / sram_write_byte_en / sram_write_data  out 1 / out LOGDEPTH / out 4 / out 32  SRAM write port; commits on the edge at which it is asserted.

Function
REQ-018 FSM states: IDLE, READ, RESP. req_ready = (state==IDLE) && !reset.
REQ-019 Accept occurs when req_valid && req_ready; word index = req_addr[LOGDEPTH+1:2].
REQ-020 Error condition: size 11; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:2] >= DEPTH. On error: no SRAM access, resp_error=1, resp_rdata=0, IDLE->RESP.
REQ-021 Legal store: sram_write_req asserted combinationally in the accept cycle, IDLE->RESP, resp_rdata=0. Response appears 1 cycle after accept.
REQ-022 Store byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-023 Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-024 Legal load: sram_read_req asserted combinationally in the accept cycle, IDLE->READ. Load fields (addr[1:0], size, signed) are registered.
REQ-025 READ: sram_read_data is shifted right by 8*addr[1:0], then masked to the access size and extended per signed. The result is registered into resp_rdata, READ->RESP. Response appears 2 cycles after accept.
REQ-026 RESP: resp_valid=1; resp_rdata and resp_error are held stable until resp_ready. RESP->IDLE on resp_ready. No new request is accepted in READ or RESP.
REQ-027 sram_read_req and sram_write_req are never asserted in the same cycle, and are never asserted outside an IDLE accept.

Reset
REQ-028 While reset=1: state=IDLE, resp_valid=0, resp_rdata=0, resp_error=0, req_ready=0, sram_read_req=0, sram_write_req=0. SRAM address and data outputs are don't-care.
REQ-029 Reset mid-operation drops any pending load or response. A store already committed at a prior edge remains in SRAM.

Structure
REQ-030 Shared defines header holds the size encodings (SIZE_B/H/W) and the FSM state encodings.
REQ-031 One combinational sub-module, load_align, implements REQ-025 (inputs: data, offset, size, signed; output: 32-bit result).

Verification
REQ-032 Preload word0=0x8000F0A5. Load byte addr 0, signed -> rdata 0xFFFFFFA5, resp_valid 2 cycles after accept.
REQ-033 Load half addr 2, unsigned -> 0x00008000. Same load with signed -> 0xFFFF8000.
REQ-034 Store byte addr 5, wdata 0x000000CC -> byte_en 0010, write_data 0xCCCCCCCC, word1 byte1=0xCC. resp_valid 1 cycle after accept, rdata 0.
REQ-035 Word load at addr 0x2, half at 0x1, size 11, and word at 4*DEPTH -> each gives resp_error=1, rdata 0, with no SRAM req asserted.
REQ-036 Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stay stable, req_ready=0 throughout. Accept follows the cycle after resp_ready=1.
REQ-037 Assert reset in READ -> resp_valid stays 0 and state returns to IDLE. The next load completes normally.
